qam_carrier_acq_ctrl: RTL and testbench
=======================================

// Module: qam_carrier_acq_ctrl
// PURPOSE
//  Acquisition/tracking sequencer for the 16QAM carrier-recovery loop (NCO, mixers, FIRs, DD, LoopFilter).
//  Steps the NCO centre phase increment across a frequency grid, switches the loop-gain set and clears the
//  loop integrator on every retune. Declares lock from a per-symbol phase-detector quality count.
//  Sits beside the carrier loop: drives the NCO carrier word and samples pd at each bitsync strobe.
// PARAMETERS
//  CENTER_FREQ 37'd34359738368  nominal phase increment (2 MHz at 8 MHz clk)
//  STEP        37'd8589935      grid spacing (~500 Hz)
//  N_STEP      4                grid index k spans -N_STEP..+N_STEP (9 points)
//  WIN         64               symbols per evaluation window (all states)
//  PD_TH       34'd16777216     symbol is "good" when |pd| < PD_TH
//  PULL_TH     40               good count needed to leave SWEEP / stay in PULLIN
//  LOCK_TH     56               good count needed to enter TRACK
//  UNLOCK_TH   32               TRACK window with good < UNLOCK_TH is a miss
//  MISS        2                consecutive missed windows that drop lock
//  MAX_SWEEPS  3                full grid passes before FAIL
// PORTS
//  clk       in   1   system clock (8 MHz)
//  rst       in   1   asynchronous reset, active high
//  enable    in   1   1 = run acquisition; 0 = return to IDLE
//  bitsync   in   1   one-cycle symbol strobe from BitSync
//  pd        in   34  signed phase-detector output from DD
//  carrier   out  37  NCO phase increment (phi_inc_i)
//  gain_sel  out  2   loop gain set: 0 off, 1 wide (pull-in), 2 narrow (track)
//  loop_clr  out  1   one-cycle pulse: clear LoopFilter integrator
//  locked    out  1   1 while in TRACK
//  failed    out  1   1 while in FAIL
//  state     out  3   IDLE=0 SWEEP=1 PULLIN=2 TRACK=3 FAIL=4
// BEHAVIOUR
//  Reset: carrier=CENTER_FREQ, gain_sel=0, loop_clr=0, locked=0, failed=0, state=IDLE, k=0, all counters 0.
//  Good test: abs(pd) saturates (-2^33 -> 2^33-1). Good if abs < PD_TH; evaluated only on bitsync.
//  Window: sym_cnt counts bitsync 0..WIN-1 and good_cnt counts good symbols; both restart on every state entry
//   or retune. The decision is taken on the bitsync with sym_cnt==WIN-1 (that symbol included), and all
//   outputs update on the next clk edge (1-cycle latency).
//  carrier = CENTER_FREQ + k*STEP (k signed, two's-complement add mod 2^37), registered.
//  loop_clr pulses for exactly one cycle, coincident with any carrier change or entry to SWEEP/IDLE from another state.
//  IDLE: gain_sel=0, k=0, sweeps=0. enable=1 -> SWEEP with k=-N_STEP, loop_clr.
//  SWEEP: gain_sel=1. Window end: good>=PULL_TH -> PULLIN (k held, no clr).
//   Otherwise retune: k<N_STEP -> k+1; k==N_STEP -> k=-N_STEP and sweeps+1.
//   sweeps reaching MAX_SWEEPS -> FAIL instead of wrapping.
//  PULLIN: gain_sel=1. Window end: good>=LOCK_TH -> TRACK (gain_sel=2).
//   good<PULL_TH -> SWEEP at next grid point (same wrap rule, loop_clr). Otherwise stay in PULLIN.
//  TRACK: locked=1, gain_sel=2. A window with good<UNLOCK_TH increments miss_cnt; any other window clears it.
//   miss_cnt==MISS -> SWEEP at the current k, sweeps=0, loop_clr.
//  FAIL: failed=1, gain_sel=0, carrier=CENTER_FREQ. Leaves only via enable=0 (-> IDLE).
//  enable=0 in any non-IDLE state -> IDLE next cycle, loop_clr, counters cleared; this overrides any window decision.
//  bitsync concurrent with a state change: that symbol is discarded (counts start at 0 in the new state).
//  Async rst mid-operation: immediate return to reset values; no loop_clr pulse is generated by reset.
// TESTING
//  1 rst, enable=1, pd=0 always, bitsync every 8 clk -> SWEEP k=-4 (carrier=CENTER-4*STEP); 64 sym -> PULLIN; 64 sym -> TRACK, locked=1, gain_sel=2.
//  2 pd=PD_TH (never good) -> k steps -4..+4, 3 full passes (27 windows) -> FAIL, failed=1, carrier=CENTER; enable=0 -> IDLE.
//  3 SWEEP: 39 good then 40 good windows -> first retunes k+1 with one loop_clr; second enters PULLIN with k unchanged.
//  4 TRACK then good=20 per window: first window miss_cnt=1 (locked stays 1); second -> SWEEP same k, loop_clr 1 cycle.
//  5 pd=-2^33 -> counted bad (saturated abs); pd=PD_TH-1 -> counted good.
//  6 enable low same cycle as a window-end bitsync in PULLIN -> IDLE (no TRACK); rst pulse mid-SWEEP -> all outputs at reset values.

Source files
------------

// File: rtl/qam_carrier_acq_ctrl_if.sv
// Purpose: bundles the control-side signals of the carrier acquisition
//   sequencer so the sequencer and its driver connect through one port.
// Signals:
//   enable   (master->slave) run acquisition when 1, return to IDLE when 0
//   bitsync  (master->slave) one-cycle symbol strobe
//   pd       (master->slave) signed 34-bit phase-detector sample
//   carrier  (slave->master) 37-bit NCO phase increment
//   gain_sel (slave->master) loop gain set: 0 off, 1 wide, 2 narrow
//   loop_clr (slave->master) one-cycle loop-filter integrator clear
//   locked / failed (slave->master) status flags
//   state    (slave->master) FSM state code for debug and checkers
// Handshake: there is no valid/ready pair here. bitsync is a strobe that
//   qualifies pd for exactly the cycle it is high. The sequencer never
//   back-pressures and samples pd only in that cycle. All slave outputs
//   are registered.
interface qam_carrier_acq_ctrl_if;
  logic        enable;
  logic        bitsync;
  logic [33:0] pd;
  logic [36:0] carrier;
  logic [1:0]  gain_sel;
  logic        loop_clr;
  logic        locked;
  logic        failed;
  logic [2:0]  state;

  modport master (
    output enable, bitsync, pd,
    input  carrier, gain_sel, loop_clr, locked, failed, state
  );

  modport slave (
    input  enable, bitsync, pd,
    output carrier, gain_sel, loop_clr, locked, failed, state
  );
endinterface

// File: rtl/qam_carrier_acq_ctrl.sv
// Purpose: acquisition/tracking sequencer for the 16QAM carrier-recovery
//   loop. It sweeps the NCO centre frequency across a grid of
//   CENTER_FREQ + k*STEP, k = -N_STEP..+N_STEP. It selects the loop gain
//   set and clears the loop integrator on every retune. It declares lock
//   from the count of symbols whose |pd| is below PD_TH within each
//   WIN-symbol window.
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active high
//   bus  qam_carrier_acq_ctrl_if.slave
//        inputs:  enable, bitsync, pd
//        outputs: carrier, gain_sel, loop_clr, locked, failed, state
module qam_carrier_acq_ctrl #(
  parameter logic [36:0] CENTER_FREQ = 37'd34359738368,
  parameter logic [36:0] STEP        = 37'd8589935,
  parameter int          N_STEP      = 4,
  parameter int          WIN         = 64,
  parameter logic [33:0] PD_TH       = 34'd16777216,
  parameter int          PULL_TH     = 40,
  parameter int          LOCK_TH     = 56,
  parameter int          UNLOCK_TH   = 32,
  parameter int          MISS        = 2,
  parameter int          MAX_SWEEPS  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  qam_carrier_acq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SWEEP  = 3'd1,
    S_PULLIN = 3'd2,
    S_TRACK  = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam int SW = $clog2(WIN);
  localparam int GW = $clog2(WIN + 1);

  localparam logic [SW-1:0]       SYM_LAST    = SW'(WIN - 1);
  localparam logic [GW-1:0]       PULL_TH_W   = GW'(PULL_TH);
  localparam logic [GW-1:0]       LOCK_TH_W   = GW'(LOCK_TH);
  localparam logic [GW-1:0]       UNLOCK_TH_W = GW'(UNLOCK_TH);
  localparam logic [1:0]          MISS_LAST   = 2'(MISS - 1);
  localparam logic [1:0]          SWEEP_LAST  = 2'(MAX_SWEEPS - 1);
  localparam logic signed [3:0]   K_MAX       = 4'(N_STEP);
  localparam logic signed [3:0]   K_MIN       = -K_MAX;
  localparam logic [33:0]         PD_MIN      = {1'b1, 33'd0};
  localparam logic [33:0]         PD_SAT      = {1'b0, {33{1'b1}}};

  state_t                state_q, state_d;
  logic signed [3:0]     k_q, k_d;
  logic [1:0]            sweeps_q, sweeps_d;
  logic [1:0]            miss_q, miss_d;
  logic [SW-1:0]         sym_cnt_q, sym_cnt_d;
  logic [GW-1:0]         good_cnt_q, good_cnt_d;
  logic [36:0]           carrier_q, carrier_d;
  logic [1:0]            gain_sel_q, gain_sel_d;
  logic                  loop_clr_q, loop_clr_d;
  logic                  locked_q, locked_d;
  logic                  failed_q, failed_d;

  logic [33:0]           pd_mag;
  logic                  sym_good;
  logic                  sym_last;
  logic [GW-1:0]         good_total;
  logic signed [3:0]     k_adv;
  logic [1:0]            sweeps_adv;
  logic                  adv_fail;
  logic [36:0]           k_ext;
  logic                  restart;

  always_comb begin
    // |pd| with the most negative code clamped, so -2^33 is never "good".
    pd_mag = 34'd0;
    if (bus.pd[33]) begin
      pd_mag = (bus.pd == PD_MIN) ? PD_SAT : (~bus.pd + 34'd1);
    end else begin
      pd_mag = bus.pd;
    end
    sym_good   = bus.bitsync && (pd_mag < PD_TH);
    sym_last   = bus.bitsync && (sym_cnt_q == SYM_LAST);
    // The closing symbol of a window takes part in its own decision.
    good_total = good_cnt_q + GW'(sym_good);

    // Next grid point, with the wrap at +N_STEP and the sweep-limit test.
    k_adv      = k_q + 4'sd1;
    sweeps_adv = sweeps_q;
    adv_fail   = 1'b0;
    if (k_q == K_MAX) begin
      k_adv = K_MIN;
      if (sweeps_q == SWEEP_LAST) begin
        adv_fail = 1'b1;
      end else begin
        sweeps_adv = sweeps_q + 2'd1;
      end
    end

    state_d  = state_q;
    k_d      = k_q;
    sweeps_d = sweeps_q;
    miss_d   = miss_q;

    // Dropping enable wins over any window decision in the same cycle.
    if (state_q != S_IDLE && !bus.enable) begin
      state_d  = S_IDLE;
      k_d      = 4'sd0;
      sweeps_d = 2'd0;
      miss_d   = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          k_d      = 4'sd0;
          sweeps_d = 2'd0;
          miss_d   = 2'd0;
          if (bus.enable) begin
            state_d = S_SWEEP;
            k_d     = K_MIN;
          end
        end
        S_SWEEP: begin
          if (sym_last) begin
            if (good_total >= PULL_TH_W) begin
              state_d = S_PULLIN;
            end else if (adv_fail) begin
              state_d = S_FAIL;
              k_d     = 4'sd0;
            end else begin
              k_d      = k_adv;
              sweeps_d = sweeps_adv;
            end
          end
        end
        S_PULLIN: begin
          if (sym_last) begin
            if (good_total >= LOCK_TH_W) begin
              state_d = S_TRACK;
              miss_d  = 2'd0;
            end else if (good_total < PULL_TH_W) begin
              if (adv_fail) begin
                state_d = S_FAIL;
                k_d     = 4'sd0;
              end else begin
                state_d  = S_SWEEP;
                k_d      = k_adv;
                sweeps_d = sweeps_adv;
              end
            end
          end
        end
        S_TRACK: begin
          if (sym_last) begin
            if (good_total < UNLOCK_TH_W) begin
              if (miss_q == MISS_LAST) begin
                // Lock lost: restart the sweep from the current grid point.
                state_d  = S_SWEEP;
                sweeps_d = 2'd0;
                miss_d   = 2'd0;
              end else begin
                miss_d = miss_q + 2'd1;
              end
            end else begin
              miss_d = 2'd0;
            end
          end
        end
        S_FAIL: begin
          k_d = 4'sd0;
        end
        default: begin
          state_d  = S_IDLE;
          k_d      = 4'sd0;
          sweeps_d = 2'd0;
          miss_d   = 2'd0;
        end
      endcase
    end

    // Window counters restart on every state change or retune. A bitsync
    // that coincides with such a change is dropped rather than counted.
    restart = (state_d != state_q) || (k_d != k_q) || sym_last ||
              (state_q == S_IDLE) || (state_q == S_FAIL);
    sym_cnt_d  = sym_cnt_q;
    good_cnt_d = good_cnt_q;
    if (restart) begin
      sym_cnt_d  = '0;
      good_cnt_d = '0;
    end else if (bus.bitsync) begin
      sym_cnt_d  = sym_cnt_q + SW'(1);
      good_cnt_d = good_total;
    end

    // Modulo-2^37 add. The sign-extended k times STEP wraps correctly.
    k_ext     = {{33{k_d[3]}}, k_d};
    carrier_d = (state_d == S_FAIL) ? CENTER_FREQ : (CENTER_FREQ + k_ext * STEP);

    loop_clr_d = (carrier_d != carrier_q) ||
                 ((state_d != state_q) && (state_d == S_SWEEP || state_d == S_IDLE));

    gain_sel_d = 2'd0;
    if (state_d == S_SWEEP || state_d == S_PULLIN) gain_sel_d = 2'd1;
    if (state_d == S_TRACK) gain_sel_d = 2'd2;
    locked_d = (state_d == S_TRACK);
    failed_d = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= 4'sd0;
      sweeps_q   <= 2'd0;
      miss_q     <= 2'd0;
      sym_cnt_q  <= '0;
      good_cnt_q <= '0;
      carrier_q  <= CENTER_FREQ;
      gain_sel_q <= 2'd0;
      loop_clr_q <= 1'b0;
      locked_q   <= 1'b0;
      failed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      sweeps_q   <= sweeps_d;
      miss_q     <= miss_d;
      sym_cnt_q  <= sym_cnt_d;
      good_cnt_q <= good_cnt_d;
      carrier_q  <= carrier_d;
      gain_sel_q <= gain_sel_d;
      loop_clr_q <= loop_clr_d;
      locked_q   <= locked_d;
      failed_q   <= failed_d;
    end
  end

  assign bus.carrier  = carrier_q;
  assign bus.gain_sel = gain_sel_q;
  assign bus.loop_clr = loop_clr_q;
  assign bus.locked   = locked_q;
  assign bus.failed   = failed_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_qam_carrier_acq_ctrl.sv
module tb_qam_carrier_acq_ctrl;

  localparam logic [36:0] CENTER   = 37'd34359738368;
  localparam logic [33:0] PD_TH    = 34'd16777216;
  localparam logic [33:0] EDGE_POS = PD_TH - 34'd1;
  localparam logic [33:0] EDGE_NEG = ~(PD_TH - 34'd1) + 34'd1;
  localparam logic [33:0] BAD_NEG  = ~PD_TH + 34'd1;
  localparam logic [33:0] NEG_MAX  = {1'b1, 33'd0};
  localparam int          GAP      = 4;

  localparam logic [2:0] ST_I = 3'd0;
  localparam logic [2:0] ST_S = 3'd1;
  localparam logic [2:0] ST_P = 3'd2;
  localparam logic [2:0] ST_T = 3'd3;
  localparam logic [2:0] ST_F = 3'd4;

  typedef struct {
    int          n_good;
    logic [33:0] good_pd;
    logic [33:0] bad_pd;
    logic [2:0]  exp_state;
    int          exp_k;
    logic [1:0]  exp_gain;
    logic        exp_locked;
    int          exp_clr;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   clr_total;
  int   clr_base;

  qam_carrier_acq_ctrl_if bus ();

  qam_carrier_acq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  // loop_clr high-cycle counter, sampled mid-cycle
  initial clr_total = 0;
  always @(negedge clk) if (bus.loop_clr === 1'b1) clr_total = clr_total + 1;

  // scoreboard helpers
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks = checks + 1;
    if (act !== exp_v) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [36:0] exp_carrier(input int k);
    logic signed [63:0] p;
    p = 64'(k) * 64'd8589935;
    return CENTER + p[36:0];
  endfunction

  task automatic check_all(input string tag, input logic [2:0] st, input int k,
                           input logic [1:0] gain, input logic lk, input int clr);
    @(negedge clk);
    #1;
    chk({tag, ".state"},    64'(bus.state),    64'(st));
    chk({tag, ".carrier"},  64'(bus.carrier),  64'(exp_carrier(k)));
    chk({tag, ".gain_sel"}, 64'(bus.gain_sel), 64'(gain));
    chk({tag, ".locked"},   64'(bus.locked),   64'(lk));
    chk({tag, ".failed"},   64'(bus.failed),   64'(st == ST_F));
    chk({tag, ".clr_cyc"},  64'(clr_total - clr_base), 64'(clr));
    clr_base = clr_total;
  endtask

  // drivers
  task automatic send_sym(input logic [33:0] v);
    repeat (GAP - 1) @(posedge clk);
    #1;
    bus.bitsync = 1'b1;
    bus.pd      = v;
    @(posedge clk);
    #1;
    bus.bitsync = 1'b0;
  endtask

  task automatic run_syms(input int n_sym, input int n_good,
                          input logic [33:0] good_pd, input logic [33:0] bad_pd);
    for (int i = 0; i < n_sym; i++) send_sym((i < n_good) ? good_pd : bad_pd);
  endtask

  task automatic set_enable(input logic v);
    @(posedge clk);
    #1;
    bus.enable = v;
    @(posedge clk);
  endtask

  vec_t vecs[16];
  int   mk;
  int   ms;
  logic fail_exp;

  initial begin
    checks   = 0;
    failures = 0;
    clr_base = 0;

    vecs[0]  = '{20, 34'd0,    PD_TH,   ST_T, -4, 2'd2, 1'b1, 0};
    vecs[1]  = '{40, 34'd0,    PD_TH,   ST_T, -4, 2'd2, 1'b1, 0};
    vecs[2]  = '{20, 34'd0,    PD_TH,   ST_T, -4, 2'd2, 1'b1, 0};
    vecs[3]  = '{20, 34'd0,    PD_TH,   ST_S, -4, 2'd1, 1'b0, 1};
    vecs[4]  = '{39, 34'd0,    PD_TH,   ST_S, -3, 2'd1, 1'b0, 1};
    vecs[5]  = '{40, 34'd0,    PD_TH,   ST_P, -3, 2'd1, 1'b0, 0};
    vecs[6]  = '{55, 34'd0,    PD_TH,   ST_P, -3, 2'd1, 1'b0, 0};
    vecs[7]  = '{39, 34'd0,    PD_TH,   ST_S, -2, 2'd1, 1'b0, 1};
    vecs[8]  = '{40, EDGE_POS, NEG_MAX, ST_P, -2, 2'd1, 1'b0, 0};
    vecs[9]  = '{56, EDGE_NEG, PD_TH,   ST_T, -2, 2'd2, 1'b1, 0};
    vecs[10] = '{31, 34'd0,    PD_TH,   ST_T, -2, 2'd2, 1'b1, 0};
    vecs[11] = '{32, 34'd0,    PD_TH,   ST_T, -2, 2'd2, 1'b1, 0};
    vecs[12] = '{31, 34'd0,    PD_TH,   ST_T, -2, 2'd2, 1'b1, 0};
    vecs[13] = '{31, 34'd0,    PD_TH,   ST_S, -2, 2'd1, 1'b0, 1};
    vecs[14] = '{39, 34'd0,    BAD_NEG, ST_S, -1, 2'd1, 1'b0, 1};
    vecs[15] = '{40, 34'd0,    NEG_MAX, ST_P, -1, 2'd1, 1'b0, 0};

    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.bitsync = 1'b0;
    bus.pd      = 34'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("reset", ST_I, 0, 2'd0, 1'b0, 0);

    // enable together with a bitsync: that symbol must not be counted
    @(posedge clk);
    #1;
    bus.enable  = 1'b1;
    bus.bitsync = 1'b1;
    bus.pd      = 34'd0;
    @(posedge clk);
    #1;
    bus.bitsync = 1'b0;
    check_all("enable", ST_S, -4, 2'd1, 1'b0, 1);
    run_syms(63, 63, 34'd0, PD_TH);
    check_all("sweep63", ST_S, -4, 2'd1, 1'b0, 0);
    run_syms(1, 1, 34'd0, PD_TH);
    check_all("sweep64", ST_P, -4, 2'd1, 1'b0, 0);
    run_syms(64, 64, 34'd0, PD_TH);
    check_all("to_track", ST_T, -4, 2'd2, 1'b1, 0);

    for (int i = 0; i < 16; i++) begin
      run_syms(64, vecs[i].n_good, vecs[i].good_pd, vecs[i].bad_pd);
      check_all($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_k,
                vecs[i].exp_gain, vecs[i].exp_locked, vecs[i].exp_clr);
    end

    // full-grid sweep with no good symbols ends in FAIL after 27 windows
    set_enable(1'b0);
    check_all("dis1", ST_I, 0, 2'd0, 1'b0, 1);
    set_enable(1'b1);
    check_all("en2", ST_S, -4, 2'd1, 1'b0, 1);
    mk = -4;
    ms = 0;
    fail_exp = 1'b0;
    for (int w = 1; w <= 27; w++) begin
      run_syms(64, 0, 34'd0, PD_TH);
      if (mk == 4) begin
        if (ms == 2) fail_exp = 1'b1;
        else begin
          mk = -4;
          ms = ms + 1;
        end
      end else begin
        mk = mk + 1;
      end
      if (fail_exp) check_all($sformatf("sweep_w%0d", w), ST_F, 0, 2'd0, 1'b0, 1);
      else          check_all($sformatf("sweep_w%0d", w), ST_S, mk, 2'd1, 1'b0, 1);
    end
    run_syms(64, 64, 34'd0, PD_TH);
    check_all("fail_hold", ST_F, 0, 2'd0, 1'b0, 0);
    set_enable(1'b0);
    check_all("fail_exit", ST_I, 0, 2'd0, 1'b0, 1);

    // enable dropped on the window-closing bitsync in PULLIN
    set_enable(1'b1);
    check_all("en3", ST_S, -4, 2'd1, 1'b0, 1);
    run_syms(64, 40, 34'd0, PD_TH);
    check_all("pull3", ST_P, -4, 2'd1, 1'b0, 0);
    run_syms(63, 63, 34'd0, PD_TH);
    repeat (GAP - 1) @(posedge clk);
    #1;
    bus.enable  = 1'b0;
    bus.bitsync = 1'b1;
    bus.pd      = 34'd0;
    @(posedge clk);
    #1;
    bus.bitsync = 1'b0;
    check_all("dis_win", ST_I, 0, 2'd0, 1'b0, 1);

    // asynchronous reset in the middle of a sweep
    set_enable(1'b1);
    check_all("en4", ST_S, -4, 2'd1, 1'b0, 1);
    run_syms(64, 0, 34'd0, PD_TH);
    check_all("retune4", ST_S, -3, 2'd1, 1'b0, 1);
    run_syms(10, 0, 34'd0, PD_TH);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst.state",    64'(bus.state),    64'(ST_I));
    chk("arst.carrier",  64'(bus.carrier),  64'(CENTER));
    chk("arst.gain_sel", 64'(bus.gain_sel), 64'd0);
    chk("arst.loop_clr", 64'(bus.loop_clr), 64'd0);
    chk("arst.locked",   64'(bus.locked),   64'd0);
    chk("arst.failed",   64'(bus.failed),   64'd0);
    bus.enable = 1'b0;
    clr_base = clr_total;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    check_all("post_rst", ST_I, 0, 2'd0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
